// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline hazard-control bundle between the datapath and pipe_hazard_ctrl.
//   master : pipeline/memory side. Drives the hazard and cache status, receives controls.
//   slave  : hazard controller. Receives status, drives enables, flushes, refill and counters.
// Status  : mem_access, cache_hit, mem_ready, idex_load, idex_rd, ifid_rs, ifid_rt, branch_taken.
// Control : pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush,
//           mem_req, refill_we, miss_count, miss_cycles.
interface pipe_hazard_ctrl_if #(
   parameter int unsigned CNT_W = 16
);
   // Status from the pipeline and main memory
   logic             mem_access;
   logic             cache_hit;
   logic             mem_ready;
   logic             idex_load;
   logic [4:0]       idex_rd;
   logic [4:0]       ifid_rs;
   logic [4:0]       ifid_rt;
   logic             branch_taken;

   // Control back to the pipeline
   logic             pc_en;
   logic             ifid_en;
   logic             idex_en;
   logic             exmem_en;
   logic             ifid_flush;
   logic             idex_flush;
   logic             memwb_flush;
   logic             mem_req;
   logic             refill_we;
   logic [CNT_W-1:0] miss_count;
   logic [CNT_W-1:0] miss_cycles;

   modport master (
      output mem_access, cache_hit, mem_ready, idex_load,
             idex_rd, ifid_rs, ifid_rt, branch_taken,
      input  pc_en, ifid_en, idex_en, exmem_en,
             ifid_flush, idex_flush, memwb_flush,
             mem_req, refill_we, miss_count, miss_cycles
   );

   modport slave (
      input  mem_access, cache_hit, mem_ready, idex_load,
             idex_rd, ifid_rs, ifid_rt, branch_taken,
      output pc_en, ifid_en, idex_en, exmem_en,
             ifid_flush, idex_flush, memwb_flush,
             mem_req, refill_we, miss_count, miss_cycles
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the five-stage pipeline with a direct-mapped D-cache.
// It handles D-cache miss refills, load-use hazards and taken branches, and keeps
// saturating miss statistics.
//   clk, rst : clock and synchronous active-high reset.
//   hz       : slave side of pipe_hazard_ctrl_if. It carries the status inputs, the
//              control outputs, and the registered miss_count and miss_cycles counters.
// The control outputs are combinational from the state and the inputs. This lets a
// miss freeze the pipeline in the same cycle that it is detected.
module pipe_hazard_ctrl #(
   parameter int unsigned CNT_W = 16
) (
   input  logic                clk,
   input  logic                rst,
   pipe_hazard_ctrl_if.slave   hz
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      MISS_WAIT = 2'd1,
      REFILL    = 2'd2
   } state_e;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] miss_count_q, miss_count_d;
   logic [CNT_W-1:0] miss_cycles_q, miss_cycles_d;

   logic miss, load_use;
   logic pc_en, ifid_en, idex_en, exmem_en;
   logic ifid_flush, idex_flush, memwb_flush;
   logic mem_req, refill_we;

   assign miss     = hz.mem_access & ~hz.cache_hit;
   // Register 0 is hard-wired to zero, so it never carries a dependency.
   assign load_use = hz.idex_load && (hz.idex_rd != 5'd0) &&
                     ((hz.idex_rd == hz.ifid_rs) || (hz.idex_rd == hz.ifid_rt));

   // Next state, counter updates and combinational pipeline controls
   always_comb begin
      state_d       = state_q;
      miss_count_d  = miss_count_q;
      miss_cycles_d = miss_cycles_q;
      pc_en         = 1'b1;
      ifid_en       = 1'b1;
      idex_en       = 1'b1;
      exmem_en      = 1'b1;
      ifid_flush    = 1'b0;
      idex_flush    = 1'b0;
      memwb_flush   = 1'b0;
      mem_req       = 1'b0;
      refill_we     = 1'b0;

      if (rst) begin
         // Hold every stage and bubble the flushable ones; any refill in flight is dropped.
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         idex_en     = 1'b0;
         exmem_en    = 1'b0;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         memwb_flush = 1'b1;
         state_d     = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (miss) begin
                  // Freeze everything up to EX/MEM and keep the missing access out of WB.
                  pc_en       = 1'b0;
                  ifid_en     = 1'b0;
                  idex_en     = 1'b0;
                  exmem_en    = 1'b0;
                  memwb_flush = 1'b1;
                  state_d     = MISS_WAIT;
                  if (miss_count_q != CNT_MAX) miss_count_d = miss_count_q + CNT_W'(1);
               end else if (load_use) begin
                  // Hold PC and IF/ID for one cycle and let a bubble enter EX.
                  // A branch in the stalled instruction resolves on the retry.
                  pc_en      = 1'b0;
                  ifid_en    = 1'b0;
                  idex_flush = 1'b1;
               end else if (hz.branch_taken) begin
                  ifid_flush = 1'b1;
               end
            end

            MISS_WAIT: begin
               pc_en       = 1'b0;
               ifid_en     = 1'b0;
               idex_en     = 1'b0;
               exmem_en    = 1'b0;
               memwb_flush = 1'b1;
               mem_req     = 1'b1;
               if (miss_cycles_q != CNT_MAX) miss_cycles_d = miss_cycles_q + CNT_W'(1);
               if (hz.mem_ready) state_d = REFILL;
            end

            REFILL: begin
               pc_en       = 1'b0;
               ifid_en     = 1'b0;
               idex_en     = 1'b0;
               exmem_en    = 1'b0;
               memwb_flush = 1'b1;
               refill_we   = 1'b1;
               if (miss_cycles_q != CNT_MAX) miss_cycles_d = miss_cycles_q + CNT_W'(1);
               state_d     = IDLE;
            end

            default: state_d = IDLE;
         endcase
      end
   end

   // State and statistics registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         miss_count_q  <= '0;
         miss_cycles_q <= '0;
      end else begin
         state_q       <= state_d;
         miss_count_q  <= miss_count_d;
         miss_cycles_q <= miss_cycles_d;
      end
   end

   assign hz.pc_en       = pc_en;
   assign hz.ifid_en     = ifid_en;
   assign hz.idex_en     = idex_en;
   assign hz.exmem_en    = exmem_en;
   assign hz.ifid_flush  = ifid_flush;
   assign hz.idex_flush  = idex_flush;
   assign hz.memwb_flush = memwb_flush;
   assign hz.mem_req     = mem_req;
   assign hz.refill_we   = refill_we;
   assign hz.miss_count  = miss_count_q;
   assign hz.miss_cycles = miss_cycles_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl. It runs two instances, CNT_W=16 and CNT_W=2, on
// identical stimulus. A behavioural reference model predicts the controls and the
// saturating counters.
module tb_pipe_hazard_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pipe_hazard_ctrl_if #(.CNT_W(16)) hz ();
   pipe_hazard_ctrl_if #(.CNT_W(2))  hs ();

   pipe_hazard_ctrl #(.CNT_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz.slave)
   );

   pipe_hazard_ctrl #(.CNT_W(2)) dut_sat (
      .clk (clk),
      .rst (rst),
      .hz  (hs.slave)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state: where the miss sequence stands, and unbounded event counts
   bit m_waiting  = 1'b0;
   bit m_refill   = 1'b0;
   int m_misses   = 0;
   int m_mcycles  = 0;

   // Current stimulus
   bit       s_rst, s_ma, s_ch, s_mr, s_il, s_bt;
   bit [4:0] s_rd, s_rs, s_rt;

   function automatic int sat(input int v, input int w);
      int mx;
      mx = (1 << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   // Expected {pc,ifid,idex,exmem, ifid_fl,idex_fl,memwb_fl, mem_req,refill_we}
   function automatic logic [8:0] exp_ctrl();
      bit lu;
      lu = s_il && (s_rd != 5'd0) && (s_rd == s_rs || s_rd == s_rt);
      if (s_rst)              return 9'b0000_111_00;
      if (m_waiting)          return 9'b0000_001_10;
      if (m_refill)           return 9'b0000_001_01;
      if (s_ma && !s_ch)      return 9'b0000_001_00;
      if (lu)                 return 9'b0011_010_00;
      if (s_bt)               return 9'b1111_100_00;
      return 9'b1111_000_00;
   endfunction

   function automatic logic [8:0] obs_main();
      return {hz.pc_en, hz.ifid_en, hz.idex_en, hz.exmem_en,
              hz.ifid_flush, hz.idex_flush, hz.memwb_flush, hz.mem_req, hz.refill_we};
   endfunction

   function automatic logic [8:0] obs_sat();
      return {hs.pc_en, hs.ifid_en, hs.idex_en, hs.exmem_en,
              hs.ifid_flush, hs.idex_flush, hs.memwb_flush, hs.mem_req, hs.refill_we};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive at negedge, check controls, clock, update model, check counters
   task automatic cycle(input string tag, input bit r, input bit ma, input bit ch,
                        input bit mr, input bit il, input bit [4:0] rd,
                        input bit [4:0] rs, input bit [4:0] rt, input bit bt);
      @(negedge clk);
      s_rst = r; s_ma = ma; s_ch = ch; s_mr = mr; s_il = il;
      s_rd = rd; s_rs = rs; s_rt = rt; s_bt = bt;
      rst = r;
      hz.mem_access = ma; hz.cache_hit = ch; hz.mem_ready = mr; hz.idex_load = il;
      hz.idex_rd = rd; hz.ifid_rs = rs; hz.ifid_rt = rt; hz.branch_taken = bt;
      hs.mem_access = ma; hs.cache_hit = ch; hs.mem_ready = mr; hs.idex_load = il;
      hs.idex_rd = rd; hs.ifid_rs = rs; hs.ifid_rt = rt; hs.branch_taken = bt;
      #1;
      check({tag, "/ctrl"},     32'(obs_main()), 32'(exp_ctrl()));
      check({tag, "/sat_ctrl"}, 32'(obs_sat()),  32'(exp_ctrl()));
      @(posedge clk);
      if (s_rst) begin
         m_waiting = 0; m_refill = 0; m_misses = 0; m_mcycles = 0;
      end else if (m_waiting) begin
         m_mcycles++;
         if (s_mr) begin m_waiting = 0; m_refill = 1; end
      end else if (m_refill) begin
         m_mcycles++;
         m_refill = 0;
      end else if (s_ma && !s_ch) begin
         m_misses++;
         m_waiting = 1;
      end
      #1;
      check({tag, "/miss_count"},      32'(hz.miss_count),  32'(sat(m_misses, 16)));
      check({tag, "/miss_cycles"},     32'(hz.miss_cycles), 32'(sat(m_mcycles, 16)));
      check({tag, "/sat_miss_count"},  32'(hs.miss_count),  32'(sat(m_misses, 2)));
      check({tag, "/sat_miss_cycles"}, 32'(hs.miss_cycles), 32'(sat(m_mcycles, 2)));
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) cycle(tag, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
   endtask

   // Miss detect, lat wait cycles with mem_ready on the last one, then refill
   task automatic miss_seq(input string tag, input int lat, input bit ready_at_detect);
      cycle({tag, "/detect"}, 0, 1, 0, ready_at_detect, 0, 5'd0, 5'd0, 5'd0, 0);
      for (int i = 1; i <= lat; i++)
         cycle({tag, "/wait"}, 0, 1, 0, (i == lat), 0, 5'd0, 5'd0, 5'd0, 0);
      cycle({tag, "/refill"}, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
   endtask

   initial begin
      rst = 1'b1;
      // Reset state
      cycle("reset", 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      cycle("reset", 1, 1, 0, 1, 1, 5'd3, 5'd3, 5'd0, 1);
      check("reset_count_zero", 32'(hz.miss_count), 32'd0);

      // Clean run
      idle("clean", 10);

      // Miss with 3-cycle latency, then the access hits
      miss_seq("miss3", 3, 0);
      cycle("miss3/hit", 0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      check("miss3_count",  32'(hz.miss_count),  32'd1);
      check("miss3_cycles", 32'(hz.miss_cycles), 32'd4);

      // mem_ready coincident with detection must be ignored
      cycle("early_rdy/detect", 0, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
      cycle("early_rdy/wait",   0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      cycle("early_rdy/wait",   0, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
      cycle("early_rdy/refill", 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      idle("early_rdy/after", 1);

      // Load-use on rt and rs, the bubble clears it; rd = 0 never stalls
      cycle("lu_rt",     0, 0, 0, 0, 1, 5'd5, 5'd1, 5'd5, 0);
      cycle("lu_bubble", 0, 0, 0, 0, 0, 5'd0, 5'd1, 5'd5, 0);
      cycle("lu_rs",     0, 1, 1, 0, 1, 5'd7, 5'd7, 5'd2, 0);
      cycle("lu_rd0",    0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0);
      cycle("lu_nomatch",0, 0, 0, 0, 1, 5'd9, 5'd8, 5'd10, 0);
      cycle("branch",    0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1);

      // Collisions
      cycle("lu_branch", 0, 0, 0, 0, 1, 5'd4, 5'd4, 5'd4, 1);
      cycle("miss_lu/detect", 0, 1, 0, 0, 1, 5'd6, 5'd6, 5'd0, 0);
      cycle("miss_lu/wait",   0, 1, 0, 1, 1, 5'd6, 5'd6, 5'd0, 1);
      cycle("miss_lu/refill", 0, 1, 0, 0, 1, 5'd6, 5'd6, 5'd0, 1);
      cycle("miss_lu/retry",  0, 1, 1, 0, 1, 5'd6, 5'd6, 5'd0, 0);
      idle("miss_lu/after", 1);

      // Reset during MISS_WAIT abandons the refill
      cycle("rst_mid/detect", 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      cycle("rst_mid/wait",   0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      cycle("rst_mid/rst",    1, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
      check("rst_mid_count",  32'(hz.miss_count),  32'd0);
      check("rst_mid_cycles", 32'(hz.miss_cycles), 32'd0);
      idle("rst_mid/after", 2);

      // Saturation: five misses, the 2-bit counter holds at 3
      for (int k = 0; k < 5; k++) miss_seq("sat", 1 + k % 2, 0);
      check("sat_count_2b",  32'(hs.miss_count), 32'd3);
      check("sat_count_16b", 32'(hz.miss_count), 32'd5);

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         cycle("rand", ($urandom_range(0, 59) == 0), 1'($urandom), ($urandom_range(0, 2) != 0),
               ($urandom_range(0, 3) == 0), 1'($urandom), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush sequencer for the five-stage MIPS pipeline with the direct-mapped data cache. It freezes and bubbles the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers on three conditions:
- data-cache misses, sequencing the main-memory refill handshake;
- load-use hazards;
- taken branches.

It also keeps saturating miss statistics.

## Interface
Parameters:
- CNT_W, 16, width of the miss-event and miss-stall-cycle counters

Ports:
- clk  in  1  pipeline clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- mem_access  in  1  MEM-stage instruction is a load or store
- cache_hit  in  1  data-cache tag match for the MEM-stage address
- mem_ready  in  1  main memory has the refill line; one-cycle pulse
- idex_load  in  1  ID/EX holds a load
- idex_rd  in  5  destination register of the ID/EX instruction
- ifid_rs, ifid_rt  in  5 each  source registers of the IF/ID instruction
- branch_taken  in  1  branch resolved taken in ID
- pc_en, ifid_en, idex_en, exmem_en  out  1 each  register load enables
- ifid_flush, idex_flush, memwb_flush  out  1 each  load a bubble (all zeros) into that register
- mem_req  out  1  refill request to main memory
- refill_we  out  1  cache line write strobe
- miss_count  out  CNT_W  number of misses since reset
- miss_cycles  out  CNT_W  number of cycles spent in MISS_WAIT or REFILL

## Operation
- FSM has three states: IDLE, MISS_WAIT, REFILL. Reset state is IDLE.
- Control outputs are combinational from the state and the inputs. Counters are registered.

IDLE, evaluated in priority order:
1. **Miss** (mem_access && !cache_hit):
   - next state MISS_WAIT;
   - pc_en, ifid_en, idex_en, exmem_en = 0;
   - memwb_flush = 1;
   - miss_count increments.
2. **Load-use** (idex_load && idex_rd != 0 && (idex_rd == ifid_rs || idex_rd == ifid_rt)):
   - pc_en = 0, ifid_en = 0;
   - idex_flush = 1;
   - exmem_en = 1; MEM/WB loads normally;
   - branch_taken is ignored this cycle.
3. **Branch** (branch_taken): ifid_flush = 1; all enables = 1.
4. **Otherwise**: all enables = 1, all flushes = 0.

MISS_WAIT:
- mem_req = 1; all enables = 0; memwb_flush = 1.
- mem_ready = 1 → REFILL. Otherwise stay.
- Hazard and branch inputs are ignored.

REFILL:
- refill_we = 1 for exactly one cycle; mem_req = 0; pipeline stays frozen; memwb_flush = 1.
- Next state is IDLE unconditionally. In that cycle the MEM-stage access re-evaluates and hits.

Counters:
- miss_cycles increments in every MISS_WAIT or REFILL cycle.
- Both counters saturate at all-ones and never wrap.

Reset:
- While rst = 1:
  - all enables = 0;
  - ifid_flush, idex_flush, memwb_flush = 1;
  - mem_req = 0, refill_we = 0.
- Next cycle: state IDLE, both counters 0.
- Reset during MISS_WAIT or REFILL abandons the refill; mem_req is low from the reset cycle onward.

## Timing
- Miss-stall length = (cycles until the mem_ready pulse) + 2. That is 1 detect cycle (IDLE) + N wait cycles + 1 REFILL cycle.
- A mem_ready pulse arriving in the same cycle as miss detection (IDLE) is ignored; memory responds only after it sees mem_req.
- Load-use stall is exactly 1 cycle. It repeats only if the condition still holds, which the inserted bubble prevents.
- A miss and a load-use condition in the same cycle: the miss wins. The load-use condition is re-evaluated after return to IDLE.
- A hit, or mem_access = 0: no effect on the pipeline.
- A register value of 0 never creates a hazard.

## Test plan
- **Clean run.** Stimulus: no miss, no hazard, no branch for 10 cycles. Required: all enables 1, all flushes 0, counters 0.
- **Miss with 3-cycle latency.**
  - Stimulus: mem_access = 1, cache_hit = 0 at cycle t; mem_ready pulsed at t+3.
  - Required, from t: enables low for cycles t..t+4; mem_req high for t+1..t+3; refill_we high at t+4; IDLE at t+5.
  - Required, after the miss: miss_count = 1, miss_cycles = 4.
- **Load-use.** Stimulus: idex_load = 1, idex_rd = 5, ifid_rt = 5. Required: pc_en = 0, ifid_en = 0, idex_flush = 1 for one cycle. Repeat with idex_rd = 0 → no stall.
- **Collisions.**
  - Load-use + branch_taken in the same cycle → ifid_flush = 0, idex_flush = 1.
  - Miss + load-use in the same cycle → miss sequence only, idex_flush = 0.
- **Reset mid-refill.** Stimulus: rst = 1 during MISS_WAIT. Required: mem_req = 0 immediately; state IDLE and counters 0 after the edge.
- **Saturation.** Stimulus: CNT_W = 2, five misses. Required: miss_count holds at 3.
